clk_sel_seq: RTL



---
 rtl/clk_sel_pkg.sv | 18 +
 rtl/clk_sel_rr_arb.sv | 38 +++
 rtl/clk_sel_seq.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/clk_sel_pkg.sv
// Shared types and constants for the clk_sel_seq clock-source sequencer.
// Optional lock feature is enabled by defining CLK_SEL_LOCK_EN.
package clk_sel_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE_OFF = 2'd1,
    SWITCH   = 2'd2,
    ACK      = 2'd3
  } state_t;

  localparam logic SEL_CLK1 = 1'b1;
  localparam logic SEL_CLK2 = 1'b0;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/clk_sel_rr_arb.sv
// Two-way round-robin arbiter; last_grant only moves on a genuine tie,
// so a lone request never disturbs who wins the next contested cycle.
module clk_sel_rr_arb
  import clk_sel_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       update
);

  logic last_grant;

  // grant[0] = requester A, grant[1] = requester B
  always_comb begin
    grant = '0;
    if (enable) begin
      if (req_a && req_b) begin
        if (last_grant == REQ_B) grant[0] = 1'b1;
        else                     grant[1] = 1'b1;
      end else begin
        grant[0] = req_a;
        grant[1] = req_b;
      end
    end
  end

  assign update = enable & req_a & req_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_grant <= REQ_B;
    else if (update) last_grant <= grant[1] ? REQ_B : REQ_A;
  end

endmodule

// File: rtl/clk_sel_seq.sv
// Glitch-free clock-source sequencer: gate off, wait, switch select, settle, gate on.
// Defining CLK_SEL_LOCK_EN adds a sel_lock input that holds off new grants in IDLE.
module clk_sel_seq
  import clk_sel_pkg::*;
#(
  parameter int unsigned GATE_WAIT   = 4,
  parameter int unsigned SETTLE_WAIT = 8,
  parameter int unsigned CNT_W       = 4,
  parameter logic        RESET_SEL   = SEL_CLK1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       sel_a,
  input  logic       req_b,
  input  logic       sel_b,
`ifdef CLK_SEL_LOCK_EN
  input  logic       sel_lock,
`endif
  output logic       ack_a,
  output logic       ack_b,
  output logic       clk_ctrl,
  output logic       clk_en,
  output logic       busy,
  output logic [7:0] sw_count
);

  localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_WAIT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_WAIT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             tgt, tgt_nxt;
  logic             gid, gid_nxt;
  logic             clk_ctrl_nxt, clk_en_nxt, ack_a_nxt, ack_b_nxt, busy_nxt;
  logic [7:0]       sw_count_nxt;

  logic       arb_en;
  logic [1:0] grant;
  logic       arb_update;
  logic       sel_g;

`ifdef CLK_SEL_LOCK_EN
  assign arb_en = (state == IDLE) && !sel_lock;
`else
  assign arb_en = (state == IDLE);
`endif

  clk_sel_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_a  (req_a),
    .req_b  (req_b),
    .enable (arb_en),
    .grant  (grant),
    .update (arb_update)
  );

  assign sel_g = grant[1] ? sel_b : sel_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (|grant) state_nxt = (sel_g == clk_ctrl) ? ACK : GATE_OFF;
      GATE_OFF: if (cnt == '0) state_nxt = SWITCH;
      SWITCH:   if (cnt == '0) state_nxt = ACK;
      ACK:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from their next values, so each one lines up with the state it belongs to.
  always_comb begin
    cnt_nxt      = cnt;
    tgt_nxt      = tgt;
    gid_nxt      = gid;
    clk_ctrl_nxt = clk_ctrl;
    clk_en_nxt   = clk_en;
    sw_count_nxt = sw_count;
    case (state)
      IDLE: begin
        if (|grant) begin
          tgt_nxt = sel_g;
          gid_nxt = grant[1] ? REQ_B : REQ_A;
          if (sel_g != clk_ctrl) begin
            clk_en_nxt = 1'b0;
            cnt_nxt    = GATE_LD;
          end
        end
      end
      GATE_OFF: begin
        if (cnt == '0) begin
          clk_ctrl_nxt = tgt;
          cnt_nxt      = SETTLE_LD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      SWITCH: begin
        if (cnt == '0) begin
          clk_en_nxt   = 1'b1;
          sw_count_nxt = sw_count + 8'd1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: ;
    endcase
    ack_a_nxt = (state_nxt == ACK) && (gid_nxt == REQ_A);
    ack_b_nxt = (state_nxt == ACK) && (gid_nxt == REQ_B);
    busy_nxt  = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      tgt      <= RESET_SEL;
      gid      <= REQ_A;
      clk_ctrl <= RESET_SEL;
      clk_en   <= 1'b1;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      busy     <= 1'b0;
      sw_count <= '0;
    end else begin
      cnt      <= cnt_nxt;
      tgt      <= tgt_nxt;
      gid      <= gid_nxt;
      clk_ctrl <= clk_ctrl_nxt;
      clk_en   <= clk_en_nxt;
      ack_a    <= ack_a_nxt;
      ack_b    <= ack_b_nxt;
      busy     <= busy_nxt;
      sw_count <= sw_count_nxt;
    end
  end

endmodule
